// File: rtl/tb_cheshire_preload_writer.sv
// Preload engine: streams (addr, data) words into memory, drains acks, then writes the entry point.
// Optional XOR checksum of stream writes when TB_CHESHIRE_PRELOAD_CHECKSUM_EN is defined.
module tb_cheshire_preload_writer #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   boot_addr_i,
  input  logic [DataWidth-1:0]   entry_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AddrWidth-1:0]   in_addr_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic                   in_last_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic                   mem_rvalid_i,
  input  logic                   mem_err_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [CntWidth-1:0]    words_o
`ifdef TB_CHESHIRE_PRELOAD_CHECKSUM_EN
  ,
  output logic [DataWidth-1:0]   checksum_o
`endif
);

  localparam int unsigned OffWidth = $clog2(DataWidth / 8);
  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, BOOT, BOOT_WAIT, DONE
  } state_e;

  state_e                 r_state;
  state_e                 w_nextState;
  logic                   r_req;
  logic                   r_last;
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_wdata;
  logic [OutWidth-1:0]    r_outstanding;
  logic [CntWidth-1:0]    r_words;
  logic                   r_error;

  logic w_accept;
  logic w_misaligned;
  logic w_grant;
  logic w_streamGrant;
  logic w_start;
  logic w_ack;

  assign w_misaligned  = |in_addr_i[OffWidth-1:0];
  assign w_accept      = in_valid_i && in_ready_o;
  assign w_grant       = mem_req_o && mem_gnt_i;
  assign w_streamGrant = r_req && mem_gnt_i;
  assign w_start       = start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_ack         = mem_rvalid_i && (r_outstanding != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: if (start_i) w_nextState = LOAD;
      LOAD: begin
        if ((w_accept && w_misaligned && in_last_i) || (w_streamGrant && r_last))
          w_nextState = DRAIN;
      end
      DRAIN:     if ((r_outstanding == '0) && !r_req) w_nextState = BOOT;
      BOOT:      if (mem_gnt_i) w_nextState = BOOT_WAIT;
      BOOT_WAIT: if (mem_rvalid_i) w_nextState = DONE;
      default:   w_nextState = IDLE;
    endcase
  end

  // The boot write borrows the memory port directly from the inputs; stream writes come from the holding registers.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    in_ready_o  = 1'b0;
    mem_req_o   = r_req;
    mem_addr_o  = r_addr;
    mem_wdata_o = r_wdata;
    case (r_state)
      LOAD: begin
        busy_o     = 1'b1;
        in_ready_o = !r_req && (r_outstanding < OutWidth'(MaxOutstanding));
      end
      DRAIN, BOOT_WAIT: busy_o = 1'b1;
      BOOT: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = boot_addr_i;
        mem_wdata_o = entry_i;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_we_o = mem_req_o;
  assign mem_be_o = {(DataWidth/8){mem_req_o}};
  assign error_o  = r_error;
  assign words_o  = r_words;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req         <= 1'b0;
      r_last        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_outstanding <= '0;
      r_words       <= '0;
      r_error       <= 1'b0;
    end else if (w_start) begin
      r_req         <= 1'b0;
      r_outstanding <= '0;
      r_words       <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_misaligned) begin
          r_error <= 1'b1;
        end else begin
          r_req   <= 1'b1;
          r_addr  <= in_addr_i;
          r_wdata <= in_data_i;
          r_last  <= in_last_i;
        end
      end else if (w_streamGrant) begin
        r_req <= 1'b0;
      end
      if (w_streamGrant && (r_words != '1)) r_words <= r_words + CntWidth'(1);
      // Acks outside an active session are stale (e.g. issued before a reset) and are dropped silently.
      if (busy_o) begin
        if (mem_rvalid_i && (mem_err_i || (r_outstanding == '0))) r_error <= 1'b1;
        case ({w_grant, w_ack})
          2'b10:   r_outstanding <= r_outstanding + OutWidth'(1);
          2'b01:   r_outstanding <= r_outstanding - OutWidth'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef TB_CHESHIRE_PRELOAD_CHECKSUM_EN
  logic [DataWidth-1:0] r_checksum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              r_checksum <= '0;
    else if (w_start)       r_checksum <= '0;
    else if (w_streamGrant) r_checksum <= r_checksum ^ r_wdata;
  end

  assign checksum_o = r_checksum;
`endif

endmodule

// File: tb/tb_tb_cheshire_preload_writer.sv
// Scoreboard bench for tb_cheshire_preload_writer: a responder models the memory port and checks
// every granted write against the expected queue filled by the stream driver.
module tb_tb_cheshire_preload_writer;

  localparam int AW = 48;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int CW = 32;
  localparam logic [AW-1:0] BootAddr = 48'h0000_0200_0040;
  localparam logic [DW-1:0] Entry    = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            isBoot;
  } exp_t;

  typedef struct {
    int t;
    bit err;
  } ack_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic [AW-1:0] in_addr_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic in_last_i = 1'b0;
  logic mem_gnt_i = 1'b0;
  logic mem_rvalid_i = 1'b0;
  logic mem_err_i = 1'b0;
  logic in_ready_o, mem_req_o, mem_we_o, busy_o, done_o, error_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic [CW-1:0] words_o;
`ifdef TB_CHESHIRE_PRELOAD_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  always #5 clk_i = ~clk_i;

  tb_cheshire_preload_writer #(
    .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO), .CntWidth(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .boot_addr_i(BootAddr), .entry_i(Entry),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
    .in_data_i(in_data_i), .in_last_i(in_last_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .words_o(words_o)
`ifdef TB_CHESHIRE_PRELOAD_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int gntEvery = 1;
  int ackDelay = 1;
  int errIdx = -1;
  int gIdx = 0;
  int myOut = 0;
  int maxOut = 0;
  int expWords = 0;
  bit expErr = 1'b0;
  logic [DW-1:0] expChk = '0;
  exp_t expQ[$];
  ack_t ackQ[$];
  bit holdValid = 1'b0;
  logic [AW-1:0] holdAddr;
  logic [DW-1:0] holdData;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides grants, replays acks after a fixed delay and scores every granted write.
  always @(negedge clk_i) begin : responder
    exp_t e;
    ack_t a;
    bit   g;
    cyc++;
    if (rst_i) begin
      mem_gnt_i = 1'b0;
      holdValid = 1'b0;
      g         = 1'b0;
    end else begin
      if (myOut >= MO) checkOutput("readyAtMax", in_ready_o, 0);
      if (mem_req_o) checkOutput("readyWhileReq", in_ready_o, 0);
      if (holdValid) begin
        checkOutput("reqHeld", mem_req_o, 1);
        checkOutput("addrHeld", mem_addr_o, holdAddr);
        checkOutput("dataHeld", mem_wdata_o, holdData);
      end
      g = mem_req_o && ((cyc % gntEvery) == 0);
      mem_gnt_i = g;
    end
    if (ackQ.size() > 0 && ackQ[0].t <= cyc) begin
      a = ackQ.pop_front();
      mem_rvalid_i = 1'b1;
      mem_err_i    = a.err;
      if (myOut > 0) myOut--;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
    end
    if (g) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedGrant", mem_req_o, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("grantAddr", mem_addr_o, e.addr);
        checkOutput("grantData", mem_wdata_o, e.data);
        checkOutput("grantWe", mem_we_o, 1);
        checkOutput("grantBe", mem_be_o, {(DW/8){1'b1}});
        if (e.isBoot) begin
          checkOutput("bootAfterAcks", myOut, 0);
          ackQ.push_back('{cyc + ackDelay, 1'b0});
        end else begin
          ackQ.push_back('{cyc + ackDelay, (gIdx == errIdx)});
          gIdx++;
        end
        myOut++;
        if (myOut > maxOut) maxOut = myOut;
      end
    end
    holdValid = !rst_i && mem_req_o && !g;
    holdAddr  = mem_addr_o;
    holdData  = mem_wdata_o;
  end

  task automatic startSession();
    @(negedge clk_i);
    start_i  = 1'b1;
    gIdx     = 0;
    maxOut   = 0;
    expWords = 0;
    expErr   = 1'b0;
    expChk   = '0;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("startBusy", busy_o, 1);
    checkOutput("startDone", done_o, 0);
    checkOutput("startError", error_o, 0);
    checkOutput("startWords", words_o, 0);
  endtask

  // Presents one stream word and holds it until accepted; returns one cycle after the handshake.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit last);
    int n = 0;
    exp_t e;
    in_valid_i = 1'b1;
    in_addr_i  = addr;
    in_data_i  = data;
    in_last_i  = last;
    while (!in_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) begin
      checkOutput("readyTimeout", in_ready_o, 1);
    end else if (addr[2:0] != 3'b000) begin
      expErr = 1'b1;
    end else begin
      e = '{addr, data, 1'b0};
      expQ.push_back(e);
      expWords++;
      expChk ^= data;
    end
    if (last) begin
      e = '{BootAddr, Entry, 1'b1};
      expQ.push_back(e);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic waitDone(input bit errAlso);
    int n = 0;
    while (!done_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("doneReached", done_o, 1);
    checkOutput("doneBusy", busy_o, 0);
    checkOutput("doneWords", words_o, expWords);
    checkOutput("doneError", error_o, expErr | errAlso);
    checkOutput("sbEmpty", expQ.size(), 0);
`ifdef TB_CHESHIRE_PRELOAD_CHECKSUM_EN
    checkOutput("checksum", checksum_o, expChk);
`endif
  endtask

  task automatic streamWords(input int count, input logic [AW-1:0] base);
    for (int i = 0; i < count; i++)
      applyStimulus(base + AW'(8 * i), {$urandom, $urandom}, (i == count - 1));
  endtask

  initial begin
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstDone", done_o, 0);
    checkOutput("rstError", error_o, 0);
    checkOutput("rstWords", words_o, 0);
    checkOutput("rstReq", mem_req_o, 0);
    checkOutput("rstReady", in_ready_o, 0);
    @(negedge clk_i);
    #2 rst_i = 1'b0;

    // Single word, zero-latency grant, ack one cycle later
    gntEvery = 1; ackDelay = 1;
    startSession();
    applyStimulus(48'h0000_8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    checkOutput("reqNextCycle", mem_req_o, 1);
    waitDone(1'b0);
    checkOutput("singleWords", words_o, 1);

    // Backpressure: sparse grants, delayed acks
    gntEvery = 3; ackDelay = 5;
    startSession();
    streamWords(10, 48'h0000_8000_1000);
    waitDone(1'b0);
    checkOutput("bpWords", words_o, 10);
    checkOutput("bpOutBound", (maxOut <= MO), 1);

    // Long ack latency drives the outstanding count to its limit
    gntEvery = 1; ackDelay = 12;
    startSession();
    streamWords(8, 48'h0000_8000_2000);
    waitDone(1'b0);
    checkOutput("hitMax", maxOut, MO);

    // Misaligned middle word is accepted but dropped
    gntEvery = 2; ackDelay = 3;
    startSession();
    applyStimulus(48'h0000_8000_0000, 64'h1111, 1'b0);
    applyStimulus(48'h0000_8000_0004, 64'h2222, 1'b0);
    checkOutput("misErrorEarly", error_o, 1);
    applyStimulus(48'h0000_8000_0010, 64'h3333, 1'b1);
    waitDone(1'b0);
    checkOutput("misWords", words_o, 2);

    // Memory error on the second write is sticky but the session completes
    gntEvery = 1; ackDelay = 2; errIdx = 1;
    startSession();
    streamWords(4, 48'h0000_8000_3000);
    waitDone(1'b1);
    checkOutput("errWords", words_o, 4);
    errIdx = -1;

    // Reset with two writes outstanding
    gntEvery = 1; ackDelay = 30;
    startSession();
    applyStimulus(48'h0000_8000_4000, 64'hA0, 1'b0);
    applyStimulus(48'h0000_8000_4008, 64'hA1, 1'b0);
    @(negedge clk_i);
    checkOutput("twoOutstanding", myOut, 2);
    #2 rst_i = 1'b1;
    myOut = 0;
    expQ.delete();
    #1;
    checkOutput("midRstBusy", busy_o, 0);
    checkOutput("midRstReq", mem_req_o, 0);
    checkOutput("midRstWords", words_o, 0);
    checkOutput("midRstError", error_o, 0);
    checkOutput("midRstReady", in_ready_o, 0);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    checkOutput("staleAckError", error_o, 0);
    checkOutput("staleAckBusy", busy_o, 0);
    checkOutput("staleAckDone", done_o, 0);
    gntEvery = 1; ackDelay = 2;
    startSession();
    streamWords(3, 48'h0000_8000_5000);
    waitDone(1'b0);

    // Small words whose XOR is easy to predict
    gntEvery = 1; ackDelay = 1;
    startSession();
    applyStimulus(48'h0000_8000_6000, 64'h1, 1'b0);
    applyStimulus(48'h0000_8000_6008, 64'h2, 1'b0);
    applyStimulus(48'h0000_8000_6010, 64'h4, 1'b1);
    waitDone(1'b0);
`ifdef TB_CHESHIRE_PRELOAD_CHECKSUM_EN
    checkOutput("checksumSeven", checksum_o, 64'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
